// File: rtl/gol_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life control path: FSM states,
// grid-memory owner encoding and the generation period helper.
package gol_ctrl_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_READY,
        S_RUN_WAIT,
        S_STEP
    } state_t;

    localparam logic [1:0] OWN_IDLE   = 2'd0;
    localparam logic [1:0] OWN_LOADER = 2'd1;
    localparam logic [1:0] OWN_CLEAR  = 2'd2;
    localparam logic [1:0] OWN_ENGINE = 2'd3;

    localparam int unsigned DEFAULT_BASE_PERIOD = 32'd25_000_000;

    // A shift large enough to empty the period still yields one step per cycle.
    function automatic logic [31:0] gen_period(input logic [31:0] base,
                                               input logic [3:0]  shift);
        logic [31:0] p;
        p = base >> shift;
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/gen_tick_timer.sv
// Generation-rate timer: counts cycles while enabled and flags expiry once the
// speed-dependent period has elapsed; the period is re-evaluated every cycle.
module gen_tick_timer
    import gol_ctrl_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEFAULT_BASE_PERIOD
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] shift,
    output logic       expire
);

    logic [31:0] tick_cnt;
    logic [31:0] period;

    assign period = gen_period(32'(BASE_PERIOD), shift);
    // A compare (not equality) lets a speed-up cut the current wait short.
    assign expire = enable && (tick_cnt >= (period - 32'd1));

    always_ff @(posedge clk_in) begin
        if (reset || clear) begin
            tick_cnt <= 32'd0;
        end else if (enable) begin
            tick_cnt <= expire ? 32'd0 : tick_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/evolution_scheduler.sv
// Game-of-Life scheduler: turns keyboard commands into handshaked requests to
// the loader, clear engine and evolution engine so only one owns grid memory.
module evolution_scheduler
    import gol_ctrl_pkg::*;
#(
    parameter int          P_PARAM_N   = 64,
    parameter int          P_PARAM_M   = 64,
    parameter int          WIDTH       = 12,
    parameter int unsigned BASE_PERIOD = DEFAULT_BASE_PERIOD
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    input  logic                 manual,
    input  logic                 reload,
    input  logic [15:0]          file_id,
    input  logic [3:0]           evo_left_shift,
    input  logic                 modify,
    input  logic [2*WIDTH-1:0]   setting_pos,
    output logic                 load_req,
    output logic [15:0]          load_file_id,
    input  logic                 load_done,
    output logic                 clear_req,
    input  logic                 clear_done,
    output logic                 step_req,
    input  logic                 step_done,
    output logic                 edit_strobe,
    output logic [2*WIDTH-1:0]   edit_pos,
    output logic [1:0]           mem_owner,
    output logic                 running,
    output logic [31:0]          gen_count
);

    localparam logic [2*WIDTH:0] CELLS = (2*WIDTH+1)'(P_PARAM_N * P_PARAM_M);

    state_t state;
    logic   start_q, pause_q, clear_q, reload_q, modify_q;
    logic   pend_clear, pend_pause, pend_load;
    logic   start_evt, pause_evt, clear_evt, load_evt, modify_evt;
    logic   edit_ok, tick_expire;

    assign start_evt  = start  & ~start_q;
    assign pause_evt  = pause  & ~pause_q;
    assign clear_evt  = clear  & ~clear_q;
    assign modify_evt = modify & ~modify_q;
    assign load_evt   = (reload & ~reload_q) | (file_id != load_file_id);
    // Cursor positions outside the grid have no cell to toggle.
    assign edit_ok    = manual && ({1'b0, setting_pos} < CELLS);

    gen_tick_timer #(
        .BASE_PERIOD (BASE_PERIOD)
    ) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (state != S_RUN_WAIT),
        .enable (state == S_RUN_WAIT),
        .shift  (evo_left_shift),
        .expire (tick_expire)
    );

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments everywhere here, so every branch sees
        // the pre-edge values of state, requests and pending flags.
        start_q  <= start;
        pause_q  <= pause;
        clear_q  <= clear;
        reload_q <= reload;
        modify_q <= modify;

        if (reset) begin
            state        <= S_LOAD;
            load_req     <= 1'b0;
            clear_req    <= 1'b0;
            step_req     <= 1'b0;
            edit_strobe  <= 1'b0;
            edit_pos     <= '0;
            running      <= 1'b0;
            gen_count    <= 32'd0;
            mem_owner    <= OWN_IDLE;
            load_file_id <= file_id;
            pend_clear   <= 1'b0;
            pend_pause   <= 1'b0;
            pend_load    <= 1'b0;
        end else begin
            edit_strobe <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    if (load_req && load_done) begin
                        load_req   <= 1'b0;
                        mem_owner  <= OWN_IDLE;
                        gen_count  <= 32'd0;
                        pend_clear <= 1'b0;
                        pend_load  <= 1'b0;
                        state      <= (pend_clear || clear_evt) ? S_CLEAR : S_READY;
                    end else begin
                        load_req   <= 1'b1;
                        mem_owner  <= OWN_LOADER;
                        pend_clear <= pend_clear | clear_evt;
                    end
                end
                S_CLEAR: begin
                    if (clear_req && clear_done) begin
                        clear_req <= 1'b0;
                        mem_owner <= OWN_IDLE;
                        gen_count <= 32'd0;
                        pend_load <= 1'b0;
                        if (pend_load || load_evt) begin
                            load_file_id <= file_id;
                            state        <= S_LOAD;
                        end else begin
                            state <= S_READY;
                        end
                    end else begin
                        clear_req <= 1'b1;
                        mem_owner <= OWN_CLEAR;
                        pend_load <= pend_load | load_evt;
                    end
                end
                S_READY: begin
                    mem_owner <= OWN_IDLE;
                    if (clear_evt) begin
                        state <= S_CLEAR;
                    end else if (load_evt) begin
                        load_file_id <= file_id;
                        state        <= S_LOAD;
                    end else if (start_evt) begin
                        running <= 1'b1;
                        state   <= S_RUN_WAIT;
                    end else if (modify_evt && edit_ok) begin
                        edit_strobe <= 1'b1;
                        edit_pos    <= setting_pos;
                    end
                end
                S_RUN_WAIT: begin
                    mem_owner <= OWN_IDLE;
                    if (clear_evt) begin
                        running <= 1'b0;
                        state   <= S_CLEAR;
                    end else if (pause_evt) begin
                        running <= 1'b0;
                        state   <= S_READY;
                    end else if (load_evt) begin
                        running      <= 1'b0;
                        load_file_id <= file_id;
                        state        <= S_LOAD;
                    end else if (tick_expire) begin
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (step_req && step_done) begin
                        step_req   <= 1'b0;
                        mem_owner  <= OWN_IDLE;
                        gen_count  <= gen_count + 32'd1;
                        pend_clear <= 1'b0;
                        pend_pause <= 1'b0;
                        pend_load  <= 1'b0;
                        if (pend_clear || clear_evt) begin
                            // A reload queued behind the clear survives into CLEAR.
                            pend_load <= pend_load | load_evt;
                            running   <= 1'b0;
                            state     <= S_CLEAR;
                        end else if (pend_load || load_evt) begin
                            load_file_id <= file_id;
                            running      <= 1'b0;
                            state        <= S_LOAD;
                        end else if (pend_pause || pause_evt) begin
                            running <= 1'b0;
                            state   <= S_READY;
                        end else begin
                            state <= S_RUN_WAIT;
                        end
                    end else begin
                        step_req   <= 1'b1;
                        mem_owner  <= OWN_ENGINE;
                        pend_clear <= pend_clear | clear_evt;
                        pend_pause <= pend_pause | pause_evt;
                        pend_load  <= pend_load  | load_evt;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
